// File: rtl/title_screen_ctrl_if.sv
// Signal bundle between the VGA/keyboard/game-logic side and the title screen controller.
// The controller uses the slave view; whoever feeds it pixels, keys and the bitmap uses the master view.
interface title_screen_ctrl_if;
    logic       frame_clk_rise;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic [7:0] keycode;
    logic       game_over;
    logic [1:0] title_bits;
    logic [3:0] title_row;
    logic [6:0] title_col;
    logic       title_on;
    logic       prompt_visible;
    logic       game_start;
    logic [1:0] state;

    modport master (
        output frame_clk_rise, DrawX, DrawY, keycode, game_over, title_bits,
        input  title_row, title_col, title_on, prompt_visible, game_start, state
    );

    modport slave (
        input  frame_clk_rise, DrawX, DrawY, keycode, game_over, title_bits,
        output title_row, title_col, title_on, prompt_visible, game_start, state
    );
endinterface

// File: rtl/title_screen_ctrl.sv
// Title screen sequencer: maps the VGA scan position onto the scaled title bitmap
// (two-stage pipeline) and runs the TITLE -> ARMED -> PLAYING -> OVER game-flow FSM,
// including the blinking "press enter" prompt and the post-game hold timer.
module title_screen_ctrl #(
    parameter int unsigned TITLE_ROWS   = 12,
    parameter int unsigned TITLE_COLS   = 89,
    parameter int unsigned SCALE_SHIFT  = 2,
    parameter int unsigned X0           = 142,
    parameter int unsigned Y0           = 120,
    parameter int unsigned BLINK_FRAMES = 30,
    parameter int unsigned HOLD_FRAMES  = 120,
    parameter logic [7:0]  START_KEY    = 8'h28
) (
    input  logic              Clk,
    input  logic              Reset_n,
    title_screen_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_TITLE   = 2'd0,
        ST_ARMED   = 2'd1,
        ST_PLAYING = 2'd2,
        ST_OVER    = 2'd3
    } state_t;

    // Box edges kept one bit wider than DrawX/DrawY so the right/bottom limits cannot overflow.
    localparam logic [10:0] X_LO = 11'(X0);
    localparam logic [10:0] X_HI = 11'(X0 + (TITLE_COLS << SCALE_SHIFT));
    localparam logic [10:0] Y_LO = 11'(Y0);
    localparam logic [10:0] Y_HI = 11'(Y0 + (TITLE_ROWS << SCALE_SHIFT));
    localparam logic [9:0]  X0_V = 10'(X0);
    localparam logic [9:0]  Y0_V = 10'(Y0);

    localparam int unsigned CNT_MAX = (BLINK_FRAMES > HOLD_FRAMES) ? BLINK_FRAMES : HOLD_FRAMES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_FRAMES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prompt_q, prompt_d;
    logic             start_q, start_d;
    logic [3:0]       row_q;
    logic [6:0]       col_q;
    logic             v1_q;
    logic             title_on_q;
    logic             in_box;
    logic             title_phase;

    // Bounds are checked on the raw coordinates, so the subtraction below only ever sees in-box pixels.
    assign in_box = ({1'b0, bus.DrawX} >= X_LO) && ({1'b0, bus.DrawX} < X_HI) &&
                    ({1'b0, bus.DrawY} >= Y_LO) && ({1'b0, bus.DrawY} < Y_HI);

    assign title_phase = (state_q == ST_TITLE) || (state_q == ST_ARMED);

    // Stage 1: register the bitmap cell index for the current scan position.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            row_q <= '0;
            col_q <= '0;
            v1_q  <= 1'b0;
        end else if (in_box) begin
            row_q <= 4'((bus.DrawY - Y0_V) >> SCALE_SHIFT);
            col_q <= 7'((bus.DrawX - X0_V) >> SCALE_SHIFT);
            v1_q  <= 1'b1;
        end else begin
            row_q <= '0;
            col_q <= '0;
            v1_q  <= 1'b0;
        end
    end

    // Stage 2: combine the ROM bits with the stage-1 valid and hide the title outside TITLE/ARMED.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            title_on_q <= 1'b0;
        end else begin
            title_on_q <= v1_q && (bus.title_bits != 2'b00) && title_phase;
        end
    end

    // FSM state, shared frame counter, prompt phase and start pulse registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= ST_TITLE;
            cnt_q    <= '0;
            prompt_q <= 1'b1;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prompt_q <= prompt_d;
            start_q  <= start_d;
        end
    end

    // Next-state logic; a state change always overrides the frame-pulse action of the same cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prompt_d = prompt_q;
        start_d  = 1'b0;
        case (state_q)
            ST_TITLE, ST_ARMED: begin
                if (bus.frame_clk_rise) begin
                    if (cnt_q == BLINK_LAST) begin
                        cnt_d    = '0;
                        prompt_d = ~prompt_q;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                if (state_q == ST_TITLE && bus.keycode == START_KEY) begin
                    state_d  = ST_ARMED;
                    cnt_d    = '0;
                    prompt_d = prompt_q;
                end else if (state_q == ST_ARMED && bus.keycode == 8'h00) begin
                    state_d  = ST_PLAYING;
                    cnt_d    = '0;
                    prompt_d = prompt_q;
                    start_d  = 1'b1;
                end
            end
            ST_PLAYING: begin
                cnt_d = '0;
                if (bus.game_over) begin
                    state_d = ST_OVER;
                end
            end
            ST_OVER: begin
                if (bus.frame_clk_rise) begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d  = ST_TITLE;
                        cnt_d    = '0;
                        prompt_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d  = ST_TITLE;
                cnt_d    = '0;
                prompt_d = 1'b1;
            end
        endcase
    end

    assign bus.title_row      = row_q;
    assign bus.title_col      = col_q;
    assign bus.title_on       = title_on_q;
    assign bus.prompt_visible = prompt_q & title_phase;
    assign bus.game_start     = start_q;
    assign bus.state          = state_q;

endmodule

// File: tb/tb_title_screen_ctrl.sv
// Directed bench for title_screen_ctrl: bitmap mapping and edges, title gating,
// start-key arming/release, prompt blink, OVER hold timer and asynchronous reset.
module tb_title_screen_ctrl;

    logic Clk;
    logic Reset_n;
    int   tests;
    int   fails;
    int   starts;

    title_screen_ctrl_if bus ();

    title_screen_ctrl dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Small stand-in for the title ROM: only a few cells are lit.
    always_comb begin
        case ({bus.title_row, bus.title_col})
            {4'd0,  7'd0}:  bus.title_bits = 2'd2;
            {4'd1,  7'd1}:  bus.title_bits = 2'd1;
            {4'd11, 7'd88}: bus.title_bits = 2'd3;
            default:        bus.title_bits = 2'd0;
        endcase
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) begin
            $display("[TB] check %s observed=%0h expected=%0h", tag, obs, exp);
        end else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic frame_pulse();
        bus.frame_clk_rise = 1'b1;
        tick();
        bus.frame_clk_rise = 1'b0;
        tick();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        starts = 0;
        Reset_n = 1'b0;
        bus.frame_clk_rise = 1'b0;
        bus.DrawX = 10'd0;
        bus.DrawY = 10'd0;
        bus.keycode = 8'h00;
        bus.game_over = 1'b0;
        tick();
        tick();
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_title_on", 32'(bus.title_on), 32'd0);
        chk("rst_prompt", 32'(bus.prompt_visible), 32'd1);
        chk("rst_start", 32'(bus.game_start), 32'd0);
        Reset_n = 1'b1;
        tick();

        // Bitmap corners and the edges just outside the box.
        bus.DrawX = 10'd497; bus.DrawY = 10'd167; tick();
        chk("br_row", 32'(bus.title_row), 32'd11);
        chk("br_col", 32'(bus.title_col), 32'd88);
        bus.DrawX = 10'd142; bus.DrawY = 10'd120; tick();
        chk("tl_row", 32'(bus.title_row), 32'd0);
        chk("tl_col", 32'(bus.title_col), 32'd0);
        chk("br_title_on", 32'(bus.title_on), 32'd1);
        bus.DrawX = 10'd141; tick();
        chk("left_out_col", 32'(bus.title_col), 32'd0);
        chk("left_out_row", 32'(bus.title_row), 32'd0);
        chk("tl_title_on", 32'(bus.title_on), 32'd1);
        bus.DrawX = 10'd498; tick();
        chk("x141_title_on", 32'(bus.title_on), 32'd0);
        bus.DrawX = 10'd0; tick();
        chk("x498_title_on", 32'(bus.title_on), 32'd0);

        // Lit cell (1,1) and unlit neighbour (1,2) in TITLE.
        bus.DrawX = 10'd146; bus.DrawY = 10'd124; tick();
        chk("c11_row", 32'(bus.title_row), 32'd1);
        chk("c11_col", 32'(bus.title_col), 32'd1);
        bus.DrawX = 10'd150; tick();
        chk("c11_title_on", 32'(bus.title_on), 32'd1);
        bus.DrawX = 10'd0; bus.DrawY = 10'd0; tick();
        chk("c12_title_on", 32'(bus.title_on), 32'd0);

        // Prompt blink: 30 frames per toggle.
        for (int i = 0; i < 29; i++) frame_pulse();
        chk("blink29_prompt", 32'(bus.prompt_visible), 32'd1);
        frame_pulse();
        chk("blink30_prompt", 32'(bus.prompt_visible), 32'd0);
        for (int i = 0; i < 29; i++) frame_pulse();
        chk("blink59_prompt", 32'(bus.prompt_visible), 32'd0);
        frame_pulse();
        chk("blink60_prompt", 32'(bus.prompt_visible), 32'd1);

        // Enter on the very pulse that would toggle the prompt: the transition wins.
        for (int i = 0; i < 29; i++) frame_pulse();
        bus.keycode = 8'h28;
        bus.frame_clk_rise = 1'b1;
        tick();
        bus.frame_clk_rise = 1'b0;
        chk("enter_state", 32'(bus.state), 32'd1);
        chk("enter_prompt", 32'(bus.prompt_visible), 32'd1);

        // Hold Enter, switch to another key, then release: one start pulse on release.
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.game_start) starts++;
        end
        bus.keycode = 8'h04;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.game_start) starts++;
        end
        chk("held_state", 32'(bus.state), 32'd1);
        chk("no_early_start", 32'(starts), 32'd0);
        bus.keycode = 8'h00; tick();
        chk("release_state", 32'(bus.state), 32'd2);
        chk("release_start", 32'(bus.game_start), 32'd1);
        chk("play_prompt", 32'(bus.prompt_visible), 32'd0);
        tick();
        chk("start_one_cycle", 32'(bus.game_start), 32'd0);

        // Title hidden while PLAYING; keys ignored.
        bus.DrawX = 10'd146; bus.DrawY = 10'd124; bus.keycode = 8'h28; tick();
        bus.DrawX = 10'd0; bus.DrawY = 10'd0; tick();
        chk("play_title_on", 32'(bus.title_on), 32'd0);
        chk("play_key_ignored", 32'(bus.state), 32'd2);
        bus.keycode = 8'h00;

        // game_over together with a frame pulse: enters OVER with counter at 0.
        bus.game_over = 1'b1; bus.frame_clk_rise = 1'b1; tick();
        bus.game_over = 1'b0; bus.frame_clk_rise = 1'b0;
        chk("over_state", 32'(bus.state), 32'd3);
        for (int i = 0; i < 119; i++) frame_pulse();
        chk("over119_state", 32'(bus.state), 32'd3);
        bus.DrawX = 10'd146; bus.DrawY = 10'd124; tick();
        bus.DrawX = 10'd0; bus.DrawY = 10'd0; tick();
        chk("over_title_on", 32'(bus.title_on), 32'd0);
        frame_pulse();
        chk("over120_state", 32'(bus.state), 32'd0);
        chk("over120_prompt", 32'(bus.prompt_visible), 32'd1);

        // game_over in TITLE is ignored; title visible again.
        bus.game_over = 1'b1; tick();
        bus.game_over = 1'b0;
        chk("title_go_ignored", 32'(bus.state), 32'd0);
        bus.DrawX = 10'd146; bus.DrawY = 10'd124; tick();
        bus.DrawX = 10'd0; bus.DrawY = 10'd0; tick();
        chk("title_again_on", 32'(bus.title_on), 32'd1);

        // Asynchronous reset just after entering PLAYING, checked before the next edge.
        bus.keycode = 8'h28; tick();
        bus.keycode = 8'h00; tick();
        chk("pre_rst_state", 32'(bus.state), 32'd2);
        Reset_n = 1'b0;
        #1;
        chk("async_state", 32'(bus.state), 32'd0);
        chk("async_title_on", 32'(bus.title_on), 32'd0);
        chk("async_prompt", 32'(bus.prompt_visible), 32'd1);
        chk("async_start", 32'(bus.game_start), 32'd0);
        Reset_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
